// File: rtl/raifes_gpio_in_filter.sv
// Pad input conditioning for the GPIO peripheral: two-flop synchroniser, per-bit
// debounce, registered rise/fall pulses and sticky interrupt-pending flags.
module raifes_gpio_in_filter #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

  logic [WIDTH-1:0]     sync1_r;
  logic [WIDTH-1:0]     sync2_r;
  logic [WIDTH-1:0]     gpio_r;
  logic [WIDTH-1:0]     rise_r;
  logic [WIDTH-1:0]     fall_r;
  logic [WIDTH-1:0]     pending_r;
  logic [CNT_WIDTH-1:0] cnt_r     [WIDTH];

  logic [CNT_WIDTH-1:0] cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0]     expire_s;
  logic [WIDTH-1:0]     gpio_nxt_s;
  logic [WIDTH-1:0]     rise_nxt_s;
  logic [WIDTH-1:0]     fall_nxt_s;
  logic [WIDTH-1:0]     pend_set_s;
  logic [WIDTH-1:0]     pending_nxt_s;

  // Two-stage synchroniser, nothing between the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= pad_i;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debounce counter next state; any cycle of agreement restarts the count.
  always_comb begin
    expire_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = '0;
      if (sync2_r[i] == gpio_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        expire_s[i]  = 1'b1;
        cnt_nxt_s[i] = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Filtered value, edge pulses and pending flags next state.
  always_comb begin
    gpio_nxt_s    = gpio_r ^ expire_s;
    rise_nxt_s    = expire_s & sync2_r;
    fall_nxt_s    = expire_s & ~sync2_r;
    // Set is taken from the pulses currently visible, so it beats a same-cycle clear.
    pend_set_s    = (rise_r & rise_en) | (fall_r & fall_en);
    pending_nxt_s = pend_set_s | (pending_r & ~irq_clr);
  end

  // Debounce counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset) begin
        cnt_r[i] <= '0;
      end else begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Registered filtered value, pulses and pending flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_r    <= '0;
      rise_r    <= '0;
      fall_r    <= '0;
      pending_r <= '0;
    end else begin
      gpio_r    <= gpio_nxt_s;
      rise_r    <= rise_nxt_s;
      fall_r    <= fall_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  assign gpio_i  = gpio_r;
  assign rise    = rise_r;
  assign fall    = fall_r;
  assign pending = pending_r;
  assign irq     = |pending_r;

  raifes_gpio_in_filter_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .gpio_i  (gpio_r),
    .rise    (rise_r),
    .fall    (fall_r),
    .pending (pending_r),
    .irq     (irq)
  );

endmodule

// Invariants of the filter outputs; no synthesised logic.
module raifes_gpio_in_filter_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  input logic [WIDTH-1:0] gpio_i,
  input logic [WIDTH-1:0] rise,
  input logic [WIDTH-1:0] fall,
  input logic [WIDTH-1:0] pending,
  input logic             irq
);

  a_no_dual_edge: assert property (@(posedge clk) disable iff (reset)
    ((rise & fall) == '0));

  a_rise_shows_one: assert property (@(posedge clk) disable iff (reset)
    ((rise & ~gpio_i) == '0));

  a_fall_shows_zero: assert property (@(posedge clk) disable iff (reset)
    ((fall & gpio_i) == '0));

  a_irq_is_or: assert property (@(posedge clk)
    (irq == (|pending)));

endmodule

// File: tb/tb_raifes_gpio_in_filter.sv
// Bench for raifes_gpio_in_filter: sliding-window reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_raifes_gpio_in_filter;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int HMAX = 4096;

  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic [W-1:0] pad_i   = 8'h00;
  logic [W-1:0] rise_en = 8'h00;
  logic [W-1:0] fall_en = 8'h00;
  logic [W-1:0] irq_clr = 8'h00;
  logic [W-1:0] gpio_i;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] pending;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  raifes_gpio_in_filter #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .CNT_WIDTH       (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pad_i   (pad_i),
    .gpio_i  (gpio_i),
    .rise    (rise),
    .fall    (fall),
    .rise_en (rise_en),
    .fall_en (fall_en),
    .irq_clr (irq_clr),
    .pending (pending),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: hist[t] is pad_i as sampled at edge t; the filtered bit flips
  // at edge t when the D synchronised samples seen at edges t-D+1..t all differ from
  // it and none of those edges precedes the last flip/reset of that bit.
  logic [W-1:0] hist [HMAX];
  int           upd  [W];
  int           t           = 2;
  bit           model_valid = 1'b0;
  logic [W-1:0] m_gpio = 8'h00;
  logic [W-1:0] m_rise = 8'h00;
  logic [W-1:0] m_fall = 8'h00;
  logic [W-1:0] m_pend = 8'h00;

  always @(posedge clk) begin : model_p
    logic [W-1:0] nr;
    logic [W-1:0] nf;
    logic [W-1:0] ng;
    bit           all_diff;
    if (t >= HMAX - 1) begin
      $display("FAIL model_history: cycle budget %0d exhausted", HMAX);
      $fatal(1, "history overflow");
    end
    hist[t] = pad_i;
    if (reset) begin
      hist[t]     = 8'h00;
      hist[t - 1] = 8'h00;
      m_gpio      = 8'h00;
      m_rise      = 8'h00;
      m_fall      = 8'h00;
      m_pend      = 8'h00;
      for (int i = 0; i < W; i++) upd[i] = t;
      model_valid = 1'b1;
    end else if (model_valid) begin
      nr = 8'h00;
      nf = 8'h00;
      ng = m_gpio;
      for (int i = 0; i < W; i++) begin
        if (t - D >= upd[i]) begin
          all_diff = 1'b1;
          for (int j = t - 1 - D; j <= t - 2; j++) begin
            if (hist[j][i] == m_gpio[i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            ng[i]  = ~m_gpio[i];
            upd[i] = t;
            if (ng[i]) nr[i] = 1'b1;
            else       nf[i] = 1'b1;
          end
        end
      end
      m_pend = (m_rise & rise_en) | (m_fall & fall_en) | (m_pend & ~irq_clr);
      m_rise = nr;
      m_fall = nf;
      m_gpio = ng;
    end
    t++;
  end

  int rise3_cnt = 0;
  int fall3_cnt = 0;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("gpio_i",  gpio_i,         m_gpio);
      check("rise",    rise,           m_rise);
      check("fall",    fall,           m_fall);
      check("pending", pending,        m_pend);
      check("irq",     {7'b0, irq},    {7'b0, |m_pend});
      if (rise[3]) rise3_cnt++;
      if (fall[3]) fall3_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    int f0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;

    // Idle with pads low.
    for (int c = 0; c < 20; c++) begin
      step(1);
      check("idle_gpio", gpio_i,      8'h00);
      check("idle_rf",   rise | fall, 8'h00);
      check("idle_pend", pending,     8'h00);
      check("idle_irq",  {7'b0, irq}, 8'h00);
    end

    // Bit 0 rises: gpio after edge k+5, pulse one cycle, pending from k+6.
    pad_i   = 8'h01;
    rise_en = 8'h01;
    step(5);
    check("lat_early_gpio", gpio_i, 8'h00);
    step(1);
    check("lat_gpio", gpio_i, 8'h01);
    check("lat_rise", rise,   8'h01);
    check("lat_pend_not_yet", pending, 8'h00);
    step(1);
    check("lat_rise_gone", rise,        8'h00);
    check("lat_pend",      pending,     8'h01);
    check("lat_irq",       {7'b0, irq}, 8'h01);

    // Three-cycle glitch on bit 3 is swallowed.
    r0 = rise3_cnt;
    f0 = fall3_cnt;
    pad_i = 8'h09;
    step(3);
    pad_i = 8'h01;
    step(10);
    check("glitch_gpio3", gpio_i & 8'h08, 8'h00);
    check("glitch_rise3", 8'(rise3_cnt - r0), 8'h00);
    check("glitch_fall3", 8'(fall3_cnt - f0), 8'h00);

    // Four-cycle pulse on bit 3 propagates, then falls back.
    pad_i = 8'h09;
    step(4);
    pad_i = 8'h01;
    step(1);
    check("pulse_gpio_pre", gpio_i, 8'h01);
    step(1);
    check("pulse_gpio_hi", gpio_i, 8'h09);
    check("pulse_rise",    rise,   8'h08);
    step(4);
    check("pulse_gpio_lo", gpio_i, 8'h01);
    check("pulse_fall",    fall,   8'h08);
    step(3);
    check("pulse_rise_cnt", 8'(rise3_cnt - r0), 8'h01);
    check("pulse_fall_cnt", 8'(fall3_cnt - f0), 8'h01);

    // Set beats a same-cycle clear on bit 5.
    irq_clr = 8'hFF;
    step(1);
    irq_clr = 8'h00;
    check("clr_all", pending, 8'h00);
    rise_en = 8'h20;
    fall_en = 8'h00;
    pad_i   = 8'h21;
    step(7);
    check("b5_pend", pending, 8'h20);
    pad_i = 8'h01;
    step(8);
    check("b5_low_gpio", gpio_i,  8'h01);
    check("b5_low_pend", pending, 8'h20);
    pad_i = 8'h21;
    step(6);
    check("b5_rise2", rise, 8'h20);
    irq_clr = 8'h20;
    step(1);
    check("b5_set_wins", pending, 8'h20);
    step(1);
    check("b5_cleared",     pending,     8'h00);
    check("b5_cleared_irq", {7'b0, irq}, 8'h00);
    irq_clr = 8'h00;

    // Enables only gate pending: bit 7 rise ignored, fall recorded.
    rise_en = 8'h00;
    fall_en = 8'hFF;
    pad_i   = 8'hA1;
    step(6);
    check("b7_rise",        rise,    8'h80);
    step(1);
    check("b7_rise_nopend", pending, 8'h00);
    pad_i = 8'h21;
    step(6);
    check("b7_fall",      fall,        8'h80);
    step(1);
    check("b7_fall_pend", pending,     8'h80);
    check("b7_fall_irq",  {7'b0, irq}, 8'h01);

    // Reset mid-debounce on bit 2 restarts the full latency.
    pad_i = 8'h04;
    step(4);
    reset = 1'b1;
    step(1);
    check("rst_gpio", gpio_i,      8'h00);
    check("rst_rf",   rise | fall, 8'h00);
    check("rst_pend", pending,     8'h00);
    check("rst_irq",  {7'b0, irq}, 8'h00);
    reset = 1'b0;
    step(5);
    check("rst_lat_early", gpio_i, 8'h00);
    step(1);
    check("rst_lat_gpio", gpio_i, 8'h04);
    check("rst_lat_rise", rise,   8'h04);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
